// File: rtl/fsm_pkg.sv
// fsm_pkg: state encodings shared by the edge detector FSMs.
// FSM_BOTH_EDGE_EN selects rising-and-falling edge detection instead of rising only.
package fsm_pkg;
    typedef enum logic [1:0] {
        M_ZERO = 2'd0,
        M_RISE = 2'd1,
        M_ONE  = 2'd2,
        M_FALL = 2'd3
    } moore_state_e;
    typedef enum logic {
        L_ZERO = 1'b0,
        L_ONE  = 1'b1
    } mealy_state_e;
`ifdef FSM_BOTH_EDGE_EN
    localparam bit BOTH_EDGES = 1'b1;
`else
    localparam bit BOTH_EDGES = 1'b0;
`endif
endpackage

// File: rtl/fsm_moore_core.sv
// fsm_moore_core: Moore edge detector, pulse decoded from the state register.
module fsm_moore_core
    import fsm_pkg::*;
(
    input  logic i_sys_clk,
    input  logic i_rst_n,
    input  logic i_data_in,
    output logic o_pulse
);
    // A 1->0 transition only reaches M_FALL when falling edges are detected
    localparam moore_state_e DROP_STATE = BOTH_EDGES ? M_FALL : M_ZERO;
    moore_state_e state_q, state_d;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_ZERO: state_d = i_data_in ? M_RISE : M_ZERO;
            M_RISE: state_d = i_data_in ? M_ONE : DROP_STATE;
            M_ONE:  state_d = i_data_in ? M_ONE : DROP_STATE;
            M_FALL: state_d = i_data_in ? M_RISE : M_ZERO;
        endcase
    end
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) state_q <= M_ZERO;
        else          state_q <= state_d;
    end
    assign o_pulse = (state_q == M_RISE) || (BOTH_EDGES && state_q == M_FALL);
endmodule

// File: rtl/edge_detect_fsm.sv
// edge_detect_fsm: Moore (registered) and Mealy (combinational) edge detectors on one bit.
// FSM_BOTH_EDGE_EN adds falling-edge pulses to both outputs.
module edge_detect_fsm
    import fsm_pkg::*;
(
    input  logic i_sys_clk,
    input  logic i_rst_n,
    input  logic i_data_in,
    output logic o_moore_fsm_out,
    output logic o_mealy_fsm_out
);
    mealy_state_e l_state_q, l_state_d;
    always_comb l_state_d = i_data_in ? L_ONE : L_ZERO;
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) l_state_q <= L_ZERO;
        else          l_state_q <= l_state_d;
    end
    // Mealy pulse leads the Moore pulse by one cycle
    assign o_mealy_fsm_out = i_rst_n &&
        ((l_state_q == L_ZERO && i_data_in) || (BOTH_EDGES && l_state_q == L_ONE && !i_data_in));
    fsm_moore_core u_moore (
        .i_sys_clk (i_sys_clk),
        .i_rst_n   (i_rst_n),
        .i_data_in (i_data_in),
        .o_pulse   (o_moore_fsm_out)
    );
endmodule

// File: tb/tb_edge_detect_fsm.sv
// tb_edge_detect_fsm: scoreboard bench; model counts edges between consecutive sampled inputs.
module tb_edge_detect_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic moore_out, mealy_out;
    typedef struct packed {
        logic mealy;
        logic moore;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    logic prev = 1'b0;

    always #10 clk = ~clk;

    edge_detect_fsm dut (
        .i_sys_clk       (clk),
        .i_rst_n         (rst_n),
        .i_data_in       (din),
        .o_moore_fsm_out (moore_out),
        .o_mealy_fsm_out (mealy_out)
    );

    function automatic logic is_edge(input logic p, input logic d);
`ifdef FSM_BOTH_EDGE_EN
        return p != d;
`else
        return !p && d;
`endif
    endfunction

    task automatic check(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, got, want);
        end
    endtask

    // Drive one cycle of stimulus mid-cycle and queue the responses it must cause.
    task automatic step(input logic r, input logic d);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        din = d;
        e.mealy = r && is_edge(prev, d);
        e.moore = r && is_edge(prev, d);
        exp_q.push_back(e);
        prev = r ? d : 1'b0;
    endtask

    // Monitor: Mealy checked late in the cycle, Moore just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #5;
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("mealy", mealy_out, e.mealy);
                @(posedge clk);
                #1;
                check("moore", moore_out, e.moore);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (10) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);
        repeat (100) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, logic'(i % 2));
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, logic'(i % 2));
        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 1)));
        repeat (3) @(negedge clk);
        check("queue_drained", logic'(exp_q.size() == 0), 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
